// File: rtl/key_dispatch_arbiter.sv
// Round-robin key dispatcher for the RC4 brute-force core array: issues keys, catches the winner, flags exhaustion.
// Optional search-duration counter enabled by defining KEYDISP_CYCLE_CNT_EN.
module key_dispatch_arbiter #(
    parameter int               NUM_CORES = 4,
    parameter int               KEY_W     = 24,
    parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       req,
    input  logic [NUM_CORES-1:0]       found,
    output logic [NUM_CORES-1:0]       grant,
    output logic [NUM_CORES*KEY_W-1:0] key_o,
    output logic                       abort,
    output logic [KEY_W-1:0]           next_key,
    output logic [KEY_W-1:0]           found_key,
    output logic                       success,
    output logic                       exhausted,
    output logic [31:0]                cycles
);

    localparam int                   PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NUM_CORES-1:0] CORE_ONE  = NUM_CORES'(1);
    localparam logic [KEY_W:0]       KEY_LIMIT = {1'b0, KEY_MAX};
    localparam logic [KEY_W:0]       KEY_ONE   = (KEY_W+1)'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FOUND, EXHAUSTED} state_t;

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [NUM_CORES-1:0]   pending_reg, pending_next;
    logic [NUM_CORES-1:0]   busy_reg, busy_next;
    logic [NUM_CORES-1:0]   grant_reg, grant_next;
    logic [KEY_W:0]         next_key_reg, next_key_next;
    logic [KEY_W-1:0]       found_key_reg, found_key_next;
    logic                   success_reg, success_next;
    logic                   exhausted_reg, exhausted_next;
    logic                   abort_reg, abort_next;

    logic [NUM_CORES-1:0]   req_eff, req_cand, ge_mask, cand_hi, cand, grant_oh;
    logic [NUM_CORES-1:0]   found_valid, found_oh;
    logic                   found_hit, key_avail, drained;
    logic [KEY_W-1:0]       key_reg [NUM_CORES];
    logic [NUM_CORES:0][PTR_W-1:0] idx_chain;
    logic [NUM_CORES:0][KEY_W-1:0] fkey_chain;
    logic [PTR_W-1:0]       grant_idx;

    // A core still sees its own request during the grant cycle; mask it so it is not re-queued.
    assign req_eff     = req & ~grant_reg;
    assign req_cand    = pending_reg | req_eff;
    assign cand_hi     = req_cand & ge_mask;
    assign cand        = (|cand_hi) ? cand_hi : req_cand;
    assign grant_oh    = cand & (~cand + CORE_ONE);
    assign found_valid = found & busy_reg;
    assign found_oh    = found_valid & (~found_valid + CORE_ONE);
    assign found_hit   = |found_valid;
    assign key_avail   = (next_key_reg <= KEY_LIMIT);
    assign drained     = ((busy_reg & ~req_eff) == '0);
    assign idx_chain[0]  = '0;
    assign fkey_chain[0] = '0;
    assign grant_idx     = idx_chain[NUM_CORES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign ge_mask[gi]      = (PTR_W'(gi) >= rr_ptr_reg);
            assign idx_chain[gi+1]  = idx_chain[gi] | (grant_oh[gi] ? PTR_W'(gi) : '0);
            assign fkey_chain[gi+1] = fkey_chain[gi] | (found_oh[gi] ? key_reg[gi] : '0);
            assign key_o[gi*KEY_W +: KEY_W] = key_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    key_reg[gi] <= '0;
                end else if (grant_next[gi]) begin
                    key_reg[gi] <= next_key_reg[KEY_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            pending_reg   <= '0;
            busy_reg      <= '0;
            grant_reg     <= '0;
            next_key_reg  <= '0;
            found_key_reg <= '0;
            success_reg   <= 1'b0;
            exhausted_reg <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            pending_reg   <= pending_next;
            busy_reg      <= busy_next;
            grant_reg     <= grant_next;
            next_key_reg  <= next_key_next;
            found_key_reg <= found_key_next;
            success_reg   <= success_next;
            exhausted_reg <= exhausted_next;
            abort_reg     <= abort_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        pending_next   = pending_reg;
        busy_next      = busy_reg;
        grant_next     = '0;
        next_key_next  = next_key_reg;
        found_key_next = found_key_reg;
        success_next   = success_reg;
        exhausted_next = exhausted_reg;
        abort_next     = abort_reg;
        case (state_reg)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) begin
                    state_next     = RUN;
                    next_key_next  = '0;
                    pending_next   = '1;
                    busy_next      = '0;
                    found_key_next = '0;
                    success_next   = 1'b0;
                    exhausted_next = 1'b0;
                    abort_next     = 1'b0;
                end
            end
            RUN: begin
                pending_next = req_cand;
                busy_next    = busy_reg & ~req_eff;
                // Found beats exhaustion and suppresses this cycle's grant.
                if (found_hit) begin
                    state_next     = FOUND;
                    found_key_next = fkey_chain[NUM_CORES];
                    success_next   = 1'b1;
                    abort_next     = 1'b1;
                end else if (!key_avail && drained) begin
                    state_next     = EXHAUSTED;
                    exhausted_next = 1'b1;
                    abort_next     = 1'b1;
                end else if (key_avail && (|req_cand)) begin
                    grant_next    = grant_oh;
                    pending_next  = req_cand & ~grant_oh;
                    busy_next     = (busy_reg & ~req_eff) | grant_oh;
                    next_key_next = next_key_reg + KEY_ONE;
                    rr_ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef KEYDISP_CYCLE_CNT_EN
    logic [31:0] cycles_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_reg <= '0;
        end else if (start && (state_reg != RUN)) begin
            cycles_reg <= '0;
        end else if ((state_reg == RUN) && (cycles_reg != 32'hFFFF_FFFF)) begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end

    assign cycles = cycles_reg;
`else
    assign cycles = 32'd0;
`endif

    assign grant     = grant_reg;
    assign abort     = abort_reg;
    assign next_key  = next_key_reg[KEY_W-1:0];
    assign found_key = found_key_reg;
    assign success   = success_reg;
    assign exhausted = exhausted_reg;

endmodule

// File: doc/key_dispatch_arbiter.md
# key_dispatch_arbiter

Parametrised key-space dispatcher for the RC4 brute-force decryption array. It hands consecutive candidate keys to NUM_CORES decryption cores on request, one grant per cycle under round-robin arbitration. It stops every core when one reports a valid decryption and records the winning key. If no core succeeds, it flags exhaustion once the key space is spent and all cores have drained. It sits between the per-core decryption_core instances and the top-level display and LED logic.

## Interface
- NUM_CORES, 4: number of decryption cores served (1..16).
- KEY_W, 24: key width in bits.
- KEY_MAX, 24'h3FFFFF: last key in the search space, inclusive.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new search.
- req  in  NUM_CORES  per-core level request for a new key; held until the matching grant.
- found  in  NUM_CORES  per-core one-cycle pulse: the current key decrypted validly.
- grant  out  NUM_CORES  one-hot, one-cycle pulse: the corresponding key_o slice is valid; drives the core's start_loop.
- key_o  out  NUM_CORES*KEY_W  per-core assigned key; core i uses bits [i*KEY_W +: KEY_W]; held between grants.
- abort  out  1  level signal to all cores to stop; high in FOUND and EXHAUSTED.
- next_key  out  KEY_W  next key to be issued; used for HEX display.
- found_key  out  KEY_W  winning key; valid when success is high.
- success  out  1  a valid key has been found.
- exhausted  out  1  search is complete with no valid key.
- cycles  out  32  search duration in cycles (see Configuration).

## Operation
- States:
  - IDLE: after reset.
  - RUN: keys are being issued.
  - FOUND and EXHAUSTED: terminal; only start leaves them.
- start in IDLE, FOUND or EXHAUSTED:
  - Go to RUN.
  - Set next_key to 0, pending to all ones, busy to all zeros.
  - Clear success, exhausted and found_key.
- start in RUN is ignored.
- Per-core registers:
  - pending[i] is set by req[i] or by entry to RUN, and cleared by grant[i].
  - busy[i] is set by grant[i] and cleared when req[i] is asserted.
- Arbitration in RUN:
  - Among pending cores, grant the first index at or after rr_ptr, wrapping modulo NUM_CORES.
  - After a grant, rr_ptr becomes the granted index + 1, wrapping.
  - Exactly one grant per cycle, and only while next_key ≤ KEY_MAX.
  - Each grant loads key_o[i] with next_key and increments next_key.
- Counter width:
  - next_key is KEY_W+1 bits internally, so KEY_MAX = 2^KEY_W − 1 does not wrap.
  - Only the low KEY_W bits are driven out.
- Found handling:
  - found[i] counts only when busy[i] is set; otherwise it is ignored.
  - If several valid found bits arrive in one cycle, the lowest index wins.
  - On a valid found: found_key gets key_o[i], success goes high, state goes to FOUND.
  - No grant is issued in that cycle.
- Exhaustion: in RUN, when next_key > KEY_MAX and busy is all zeros, go to EXHAUSTED and set exhausted.
- Found and exhaustion in the same cycle: found takes priority, so success = 1 and exhausted = 0.
- In FOUND and EXHAUSTED: grant is zero, abort is high, req and found are ignored.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, pending 0, busy 0.
  - grant 0, key_o 0, abort 0, next_key 0, found_key 0.
  - success 0, exhausted 0, cycles 0.
- All outputs are registered.
- Latency:
  - req[i] at edge n produces grant[i] at edge n+1 at the earliest.
  - The first grant after start comes one cycle after entering RUN.
- key_o[i] changes only in the same cycle that grant[i] is high.
- found at edge n puts success and abort high after edge n+1.
- rst mid-search returns everything to reset values immediately; grant is forced low asynchronously.

## Configuration
- KEYDISP_CYCLE_CNT_EN defined:
  - cycles clears on start, increments each cycle in RUN, and freezes on entering FOUND or EXHAUSTED.
  - The count saturates at 32'hFFFFFFFF.
- Undefined: cycles is tied to 0 and no counter logic is built.

## Test plan
- Reset with NUM_CORES=4, start pulse, all req low -> grants to cores 0,1,2,3 on consecutive cycles with keys 0,1,2,3; next_key = 4.
- All four req asserted in the same cycle while rr_ptr = 2 -> grant order 2,3,0,1; keys increment by 1 per grant.
- found[1] while core 1 holds key 0x00002A -> success = 1, found_key = 0x00002A, abort = 1, no further grants. found[2] in the same cycle -> core 1 still wins.
- KEY_MAX = 5 with cores repeatedly requesting and never finding -> keys 0..5 issued once each. Once busy drains to 0: exhausted = 1, abort = 1.
- Final core reports found in the same cycle that exhaustion would trigger -> success = 1, exhausted = 0.
- rst asserted mid-RUN -> all outputs 0 without waiting for a clock edge. Following start -> search restarts at key 0. With KEYDISP_CYCLE_CNT_EN, cycles counts from 0 again.
